// File: rtl/wb_cmd_exec.sv
// Wishbone bus executive: turns edge-qualified 34-bit host commands into single
// Wishbone classic cycles and returns a 34-bit response word with a one-cycle strobe.
module wb_cmd_exec #(
  parameter int AW      = 30,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [33:0]   cmd_word,
  input  logic          i_stb,
  output logic          o_busy,
  output logic          o_drop,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [AW-1:0] wb_adr,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel,
  input  logic          wb_ack,
  input  logic          wb_err,
  input  logic [31:0]   wb_dat_i,
  output logic          o_rsp_stb,
  output logic [33:0]   o_rsp_word
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADDR  = 2'b10;

  localparam logic [33:0] RSP_WRITE = {2'b10, 32'h0};
  localparam logic [33:0] RSP_ERR   = {2'b11, 32'h0};

  state_t        state_q, state_d;
  logic          stb_q, stb_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          inc_q, inc_d;
  logic          we_q, we_d;
  logic [31:0]   dat_q, dat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;
  logic          rsp_stb_q, rsp_stb_d;
  logic [33:0]   rsp_word_q, rsp_word_d;
  logic          cmd_edge;

  assign cmd_edge = i_stb & ~stb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      stb_q      <= 1'b0;
      adr_q      <= '0;
      inc_q      <= 1'b0;
      we_q       <= 1'b0;
      dat_q      <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      rsp_stb_q  <= 1'b0;
      rsp_word_q <= '0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      adr_q      <= adr_d;
      inc_q      <= inc_d;
      we_q       <= we_d;
      dat_q      <= dat_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      rsp_stb_q  <= rsp_stb_d;
      rsp_word_q <= rsp_word_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stb_d      = i_stb;
    adr_d      = adr_q;
    inc_d      = inc_q;
    we_d       = we_q;
    dat_d      = dat_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    rsp_stb_d  = 1'b0;
    rsp_word_d = rsp_word_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_edge) begin
          unique case (cmd_word[33:32])
            OP_READ: begin
              state_d = BUS;
              we_d    = 1'b0;
              cnt_d   = '0;
            end
            OP_WRITE: begin
              state_d = BUS;
              we_d    = 1'b1;
              dat_d   = cmd_word[31:0];
              cnt_d   = '0;
            end
            OP_ADDR: begin
              adr_d = cmd_word[AW-1:0];
              inc_d = cmd_word[30];
            end
            default: begin
              drop_d = 1'b0;
              adr_d  = '0;
              inc_d  = 1'b0;
            end
          endcase
        end
      end
      BUS: begin
        if (cmd_edge) drop_d = 1'b1;
        // err outranks ack; only a clean ack may advance the address
        if (wb_err) begin
          state_d    = IDLE;
          rsp_stb_d  = 1'b1;
          rsp_word_d = RSP_ERR;
        end else if (wb_ack) begin
          state_d    = IDLE;
          rsp_stb_d  = 1'b1;
          rsp_word_d = we_q ? RSP_WRITE : {2'b01, wb_dat_i};
          if (inc_q) adr_d = adr_q + AW'(1);
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          rsp_stb_d  = 1'b1;
          rsp_word_d = RSP_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy     = (state_q == BUS);
  assign o_drop     = drop_q;
  assign wb_cyc     = (state_q == BUS);
  assign wb_stb     = (state_q == BUS);
  assign wb_we      = we_q;
  assign wb_adr     = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel     = 4'hF;
  assign o_rsp_stb  = rsp_stb_q;
  assign o_rsp_word = rsp_word_q;

endmodule

// File: tb/tb_wb_cmd_exec.sv
// Directed bench for wb_cmd_exec: expected responses queued at issue time, popped by
// a monitor on every response strobe; a behavioural slave answers bus cycles.
module tb_wb_cmd_exec;
  localparam int AW = 30;
  localparam int TO = 8;

  logic          clk, rst;
  logic [33:0]   cmd_word;
  logic          i_stb;
  logic          o_busy, o_drop, wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [31:0]   wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel;
  logic          wb_ack, wb_err, o_rsp_stb;
  logic [33:0]   o_rsp_word;

  wb_cmd_exec #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_word(cmd_word), .i_stb(i_stb),
    .o_busy(o_busy), .o_drop(o_drop), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel(wb_sel),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_dat_i(wb_dat_i),
    .o_rsp_stb(o_rsp_stb), .o_rsp_word(o_rsp_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [33:0] exp_q[$];
  int n_exp = 0;
  int rsp_cnt = 0;

  // bus-cycle observations
  int            bus_cnt = 0;
  int            cur_len = 0;
  int            last_len = 0;
  logic          prev_cyc = 1'b0;
  logic [AW-1:0] last_adr;
  logic          last_we;
  logic [31:0]   last_dat;
  logic [3:0]    last_sel;

  // slave configuration: mode 0 ack, 1 err, 2 ack+err, 3 silent
  int          slv_mode = 0;
  int          slv_delay = 0;
  logic [31:0] slv_data = 32'h0;
  int          scnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [33:0] e);
    exp_q.push_back(e);
    n_exp++;
  endtask

  task automatic send(input logic [33:0] c, input int hold);
    @(negedge clk);
    cmd_word = c;
    i_stb    = 1'b1;
    repeat (hold) @(negedge clk);
    i_stb = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 200 && rsp_cnt < n_exp; i++) @(negedge clk);
    if (rsp_cnt < n_exp) chk("rsp_wait_expired", 64'(rsp_cnt), 64'(n_exp));
    @(negedge clk);
  endtask

  // slave: answers on the (slv_delay+1)-th cycle of a bus cycle
  always @(negedge clk) begin
    if (wb_cyc && wb_stb) begin
      scnt = scnt + 1;
      if (slv_mode != 3 && scnt - 1 == slv_delay) begin
        wb_ack   = (slv_mode == 0 || slv_mode == 2);
        wb_err   = (slv_mode == 1 || slv_mode == 2);
        wb_dat_i = slv_data;
      end else begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
      end
    end else begin
      scnt   = 0;
      wb_ack = 1'b0;
      wb_err = 1'b0;
    end
  end

  // monitor: response scoreboard plus bus-cycle capture and stability
  always @(negedge clk) begin
    if (o_rsp_stb) begin
      rsp_cnt = rsp_cnt + 1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got %h expected none", o_rsp_word);
      end else begin
        chk("rsp_word", 64'(o_rsp_word), 64'(exp_q.pop_front()));
      end
    end
    if (wb_cyc) begin
      if (!prev_cyc) begin
        bus_cnt++;
        cur_len  = 1;
        last_adr = wb_adr;
        last_we  = wb_we;
        last_dat = wb_dat_o;
        last_sel = wb_sel;
      end else begin
        cur_len++;
        chk("bus_hold", {wb_stb, wb_we, wb_adr, wb_dat_o}, {1'b1, last_we, last_adr, last_dat});
      end
    end else if (prev_cyc) begin
      last_len = cur_len;
    end
    prev_cyc = wb_cyc;
  end

  int b0;

  initial begin
    rst = 1'b1; i_stb = 1'b0; cmd_word = '0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_bus", {wb_cyc, wb_stb, wb_we, o_busy, o_drop}, 64'h0);
    chk("reset_adr_dat", {wb_adr, wb_dat_o}, 64'h0);
    chk("reset_rsp", {o_rsp_stb, o_rsp_word}, 64'h0);
    rst = 1'b0;

    // 1: ADDR then READ with 3-cycle-late ack, 1-cycle latency
    slv_mode = 0; slv_delay = 3; slv_data = 32'hDEADBEEF;
    send(34'h200000010, 2);
    b0 = bus_cnt;
    push(34'h1DEADBEEF);
    @(negedge clk); cmd_word = 34'h000000000; i_stb = 1'b1;
    @(negedge clk);
    chk("read_latency", {wb_cyc, wb_stb, o_busy}, 3'b111);
    @(negedge clk); i_stb = 1'b0;
    wait_rsp();
    chk("t1_adr", 64'(last_adr), 64'h10);
    chk("t1_we", 64'(last_we), 64'h0);
    chk("t1_one_cycle", 64'(bus_cnt - b0), 64'h1);
    // strobe held across completion must not retrigger nor count as a drop
    slv_delay = 0; slv_data = 32'h11112222;
    b0 = bus_cnt;
    push(34'h111112222);
    send(34'h000000000, 10);
    wait_rsp();
    chk("held_stb_one_cycle", 64'(bus_cnt - b0), 64'h1);
    chk("held_stb_no_drop", 64'(o_drop), 64'h0);

    // 2: auto-increment writes
    send(34'h240000000, 2);
    for (int i = 1; i <= 3; i++) begin
      push(34'h200000000);
      send({2'b01, 32'(i)}, 2);
      wait_rsp();
      chk("t2_adr", 64'(last_adr), 64'(i - 1));
      chk("t2_dat", 64'(last_dat), 64'(i));
      chk("t2_we_sel", {last_we, last_sel}, 5'b11111);
    end
    slv_data = 32'h12345678;
    push(34'h112345678);
    send(34'h000000000, 2);
    wait_rsp();
    chk("t2_final_adr", 64'(last_adr), 64'h3);

    // 3: timeout, address held
    slv_mode = 3;
    push(34'h300000000);
    send(34'h000000000, 2);
    wait_rsp();
    chk("timeout_len", 64'(last_len), 64'(TO));
    slv_mode = 0; slv_data = 32'hA5A5A5A5;
    push(34'h1A5A5A5A5);
    send(34'h000000000, 2);
    wait_rsp();
    chk("timeout_no_inc", 64'(last_adr), 64'h4);

    // 4: ack+err together, then err alone: error response, no increment
    slv_mode = 2; slv_delay = 1;
    push(34'h300000000);
    send(34'h000000000, 2);
    wait_rsp();
    slv_mode = 1;
    push(34'h300000000);
    send(34'h1000000AA, 2);
    wait_rsp();
    slv_mode = 0; slv_delay = 0; slv_data = 32'h0000BEEF;
    push(34'h10000BEEF);
    send(34'h000000000, 2);
    wait_rsp();
    chk("err_no_inc", 64'(last_adr), 64'h5);

    // address wrap at 2^AW
    send(34'h27FFFFFFF, 1);
    push(34'h200000000);
    send(34'h155555555, 1);
    wait_rsp();
    chk("wrap_top_adr", 64'(last_adr), 64'h3FFFFFFF);
    slv_data = 32'h0BADF00D;
    push(34'h10BADF00D);
    send(34'h000000000, 1);
    wait_rsp();
    chk("wrap_zero_adr", 64'(last_adr), 64'h0);

    // 5: edge while busy sets drop; SPECIAL clears drop and address
    slv_delay = 5; slv_data = 32'h600DF00D;
    b0 = bus_cnt;
    push(34'h1600DF00D);
    send(34'h000000000, 1);
    @(negedge clk);
    send(34'h1FFFFFFFF, 1);
    wait_rsp();
    chk("drop_set", 64'(o_drop), 64'h1);
    chk("drop_one_cycle", 64'(bus_cnt - b0), 64'h1);
    chk("drop_we", 64'(last_we), 64'h0);
    send(34'h300000000, 1);
    @(negedge clk);
    chk("special_clr", 64'(o_drop), 64'h0);
    slv_delay = 0; slv_data = 32'h00000001;
    push(34'h100000001);
    send(34'h000000000, 1);
    wait_rsp();
    chk("special_adr", 64'(last_adr), 64'h0);

    // 6: reset mid-bus; strobe held through release is a fresh edge
    slv_mode = 3;
    send(34'h000000000, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_bus", {wb_cyc, wb_stb, o_busy, o_rsp_stb}, 4'b0000);
    chk("rst_rsp_word", 64'(o_rsp_word), 64'h0);
    slv_mode = 0; slv_data = 32'hCAFEF00D;
    cmd_word = 34'h000000000; i_stb = 1'b1;
    push(34'h1CAFEF00D);
    @(negedge clk);
    rst = 1'b0;
    wait_rsp();
    i_stb = 1'b0;
    chk("rst_then_read_adr", 64'(last_adr), 64'h0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_cmd_exec.md
Name: wb_cmd_exec

Overview:
- Wishbone bus executive. It sits directly downstream of the host command converter.
- It consumes 34-bit command words qualified by a strobe, runs one Wishbone classic cycle per bus command against the SPI-master/peripheral bus, and returns a 34-bit response word with a one-cycle strobe for the host FIFO path.
- It keeps an address register, with optional auto-increment, that persists between commands.

Parameters:
- AW, 30: Wishbone word-address width (≤30).
- TIMEOUT, 255: max cycles a bus cycle may wait for ack/err before abort (≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_word  in  34  command: [33:32] opcode, [31:0] payload.
- i_stb  in  1  command qualifier; may stay high for several cycles per command.
- o_busy  out  1  high while a bus cycle is outstanding.
- o_drop  out  1  sticky: a command arrived while busy.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  Wishbone write enable.
- wb_adr  out  AW  Wishbone word address.
- wb_dat_o  out  32  Wishbone write data.
- wb_sel  out  4  byte selects; constant 4'hF.
- wb_ack  in  1  Wishbone acknowledge.
- wb_err  in  1  Wishbone error.
- wb_dat_i  in  32  Wishbone read data.
- o_rsp_stb  out  1  one-cycle response valid.
- o_rsp_word  out  34  response word.

Behaviour:
- Reset values: wb_cyc=0, wb_stb=0, wb_we=0, wb_adr=0, wb_dat_o=0, o_busy=0, o_drop=0, o_rsp_stb=0, o_rsp_word=0. Internal address=0, inc flag=0, state=IDLE.
- Command acceptance is edge-based: a command is taken when i_stb=1 and the registered i_stb from the previous cycle =0. This is a single take per multi-cycle strobe.
  - No retrigger while i_stb stays high, including across command completion.
  - cmd_word is sampled in the acceptance cycle.
- Opcodes, by cmd_word[33:32]:
  - 2'b00 READ: Wishbone read at the address register.
  - 2'b01 WRITE: Wishbone write of payload[31:0] at the address register.
  - 2'b10 ADDR: address <= payload[AW-1:0]; inc flag <= payload[30]. No bus cycle, no response; completes in the acceptance cycle. Example: 34'h200000001 sets address=1, inc=0.
  - 2'b11 SPECIAL: clears o_drop, address<=0, inc<=0. No bus cycle, no response.
- States:
  - IDLE: accepting an edge with a READ/WRITE opcode moves to BUS next cycle. Latency is 1: edge at cycle N gives wb_cyc=wb_stb=1 at N+1, with wb_adr, wb_we and wb_dat_o valid from N+1 and held stable until termination.
  - BUS: wb_cyc and wb_stb both held high until termination. o_busy=1. The timeout counter starts at 0 on entry and increments each cycle without ack/err.
  - Termination:
    - wb_ack at cycle M: cyc/stb=0 at M+1; o_rsp_stb=1 for exactly cycle M+1; state IDLE at M+1.
    - wb_err at cycle M: same timing as ack, with the error response.
    - ack and err in the same cycle: err wins.
    - ack in the first BUS cycle is legal.
    - Timeout: counter reaches TIMEOUT-1 with no ack/err → cyc/stb drop next cycle, with an error response.
- Response words:
  - READ: {2'b01, wb_dat_i captured at the ack cycle}.
  - WRITE: {2'b10, 32'h0}.
  - Error or timeout: {2'b11, 32'h0}.
  - o_rsp_word holds its last value when o_rsp_stb=0.
- Auto-increment: if inc=1, the address increments by 1 (mod 2^AW, wrapping to 0) on successful ack only. No increment on err or timeout.
- o_busy: 1 from the cycle after acceptance through the termination cycle. It is 0 in the cycle o_rsp_stb=1, so a new edge in that same cycle is accepted.
- Command edge while o_busy=1: the command is ignored, o_drop<=1, and the bus cycle is unaffected.
- rst at any point, including mid-cycle: all outputs return to reset values next cycle, no response is issued, and the edge detector is cleared. An i_stb held high through reset release is then treated as a new edge.

Test Plan:
1. ADDR 34'h200000010, then READ 34'h000000000 (i_stb high 2 cycles each); slave acks 3 cycles after stb with 32'hDEADBEEF → wb_adr=0x10, wb_we=0, one o_rsp_stb with o_rsp_word=34'h1DEADBEEF; single bus cycle per 2-cycle strobe.
2. ADDR 34'h240000000 (inc=1, addr 0), then three WRITEs with 32'h1, 32'h2, 32'h3, immediate acks → wb_adr 0,1,2 with matching wb_dat_o and wb_sel=4'hF; three responses 34'h200000000; final address 3.
3. READ with no ack, TIMEOUT=8 → cyc/stb high exactly 8 cycles, then response 34'h300000000; address unchanged with inc=1.
4. wb_ack and wb_err asserted in the same cycle → response 34'h300000000, no increment; wb_err alone → same response.
5. Second command edge while busy → o_drop=1, bus cycle completes normally with one response; SPECIAL 34'h300000000 → o_drop=0, address=0.
6. rst asserted mid-BUS → next cycle cyc/stb/o_busy=0, no o_rsp_stb; the following READ proceeds at address 0.
